mdu_hilo: RTL and testbench

- Multiply/divide unit with HI/LO registers; sits directly downstream of the register file.
- Consumes RD1/RD2 as operands A/B.
- Executes MULT/MULTU/DIV/DIVU iteratively, plus MTHI/MTLO.
- Exposes HI/LO to the writeback mux for MFHI/MFLO; busy stalls the PC/control while an operation runs.

---
 rtl/mdu_hilo.sv | 227 ++++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// -----------------------------------------------------------------------------
// mdu_hilo
//
// Multiply/divide unit with HI/LO registers. It sits downstream of the register
// file and takes RD1/RD2 as operands A/B. MULT/MULTU/DIV/DIVU run iteratively,
// one bit per cycle for WIDTH cycles, and then take one more cycle for sign
// correction. MTHI/MTLO write HI/LO directly in a single cycle.
//
// Ports:
//   clk    in   rising-edge system clock
//   rst    in   asynchronous active-low reset; clears all state
//   start  in   request strobe, accepted only while the unit is idle
//   op     in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//               11x reserved (ignored)
//   A      in   operand rs (RD1)
//   B      in   operand rt (RD2)
//   busy   out  high while a multiply/divide is in flight (stalls PC/control)
//   done   out  one-cycle pulse when HI/LO take a multiply/divide result
//   HI     out  HI register (product high half / remainder)
//   LO     out  LO register (product low half / quotient)
//
// Build option:
//   MDU_FAST_MUL_EN  when defined, MULT/MULTU use a single-cycle array
//                    multiplier and skip the iterative phase; divide is
//                    unchanged. When undefined, no multiplier array exists.
// -----------------------------------------------------------------------------
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpMthi = 3'b100;
  localparam logic [2:0] OpMtlo = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  // Architectural and control state
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Datapath state for the operation in flight.
  // r_acc holds {partial product high, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rawA;
  logic               r_isDiv;
  logic               r_negLo;
  logic               r_negHi;
  logic               r_divZero;

  // Request decode and operand magnitudes
  logic               w_isMulOp;
  logic               w_isDivOp;
  logic               w_signedOp;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;

  // Iteration datapath
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_remShift;
  logic [WIDTH-1:0]   w_remSub;
  logic               w_qBit;
  logic [2*WIDTH-1:0] w_divNext;

  // Sign-correction datapath
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prodFix;
  logic [WIDTH-1:0]   w_quotFix;
  logic [WIDTH-1:0]   w_remFix;
  logic [WIDTH-1:0]   w_fixHi;
  logic [WIDTH-1:0]   w_fixLo;

  assign busy = r_busy;
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

  // Decode the request and form operand magnitudes. The signed ops are the
  // ones with op[0]=0 among the mul/div group; the most negative value maps
  // to itself, which is the correct unsigned magnitude.
  always_comb begin
    w_isMulOp  = (op[2:1] == 2'b00);
    w_isDivOp  = (op[2:1] == 2'b01);
    w_signedOp = (op[2] == 1'b0) && (op[0] == 1'b0);
    w_absA     = (w_signedOp && A[WIDTH-1]) ? -A : A;
    w_absB     = (w_signedOp && B[WIDTH-1]) ? -B : B;
  end

  // One radix-2 step of each algorithm. Multiply adds the multiplicand into
  // the upper half when the current multiplier bit is set, then shifts right
  // with the carry. Divide shifts the next dividend bit into the remainder and
  // subtracts the divisor when it fits (restoring), shifting the quotient bit
  // in at the bottom as the dividend bits leave the top.
  always_comb begin
    w_mulSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                 (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    w_mulNext  = {w_mulSum, r_acc[WIDTH-1:1]};

    w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
    w_qBit     = (w_remShift >= {1'b0, r_opnd});
    w_remSub   = w_remShift[WIDTH-1:0] - r_opnd;
    w_divNext  = w_qBit ? {w_remSub,               r_acc[WIDTH-2:0], 1'b1}
                        : {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
  end

  // Final product source: the iterated accumulator, or the array product of
  // the latched magnitudes when the fast multiplier is built in.
`ifdef MDU_FAST_MUL_EN
  assign w_prod = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, r_opnd};
`else
  assign w_prod = r_acc;
`endif

  // Sign correction applied on the FIX edge. The quotient is negated when the
  // operand signs differ (truncation toward zero) and the remainder follows
  // the dividend sign. Divide by zero is overridden to all-ones/A. The signed
  // overflow case (min / -1) needs no special handling: the magnitude quotient
  // is 0x80..0 with no negation, remainder zero.
  always_comb begin
    w_prodFix = r_negLo ? -w_prod : w_prod;
    w_quotFix = r_negLo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_remFix  = r_negHi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    if (!r_isDiv) begin
      w_fixHi = w_prodFix[2*WIDTH-1:WIDTH];
      w_fixLo = w_prodFix[WIDTH-1:0];
    end else if (r_divZero) begin
      w_fixHi = r_rawA;
      w_fixLo = {WIDTH{1'b1}};
    end else begin
      w_fixHi = w_remFix;
      w_fixLo = w_quotFix;
    end
  end

  // Control FSM with registered outputs. Requests are only looked at in IDLE,
  // so a start while busy is simply dropped. HI/LO change only on MTHI/MTLO
  // accept or on the FIX edge, so old values stay readable during CALC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_rawA    <= '0;
      r_isDiv   <= 1'b0;
      r_negLo   <= 1'b0;
      r_negHi   <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (op == OpMthi) begin
              r_hi <= A;
            end else if (op == OpMtlo) begin
              r_lo <= A;
            end else if (w_isMulOp || w_isDivOp) begin
              r_opnd    <= w_absB;
              r_acc     <= {{WIDTH{1'b0}}, w_absA};
              r_rawA    <= A;
              r_isDiv   <= w_isDivOp;
              r_negLo   <= w_signedOp && (A[WIDTH-1] ^ B[WIDTH-1]);
              r_negHi   <= w_isDivOp && w_signedOp && A[WIDTH-1];
              r_divZero <= w_isDivOp && (B == '0);
              r_cnt     <= '0;
              r_busy    <= 1'b1;
`ifdef MDU_FAST_MUL_EN
              r_state   <= w_isMulOp ? FIX : CALC;
`else
              r_state   <= CALC;
`endif
            end
          end
        end

        CALC: begin
          r_acc <= r_isDiv ? w_divNext : w_mulNext;
          if (r_cnt == CW'(WIDTH-1)) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        FIX: begin
          r_hi    <= w_fixHi;
          r_lo    <= w_fixLo;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// -----------------------------------------------------------------------------
// tb_mdu_hilo
//
// Directed testbench for mdu_hilo (WIDTH=32). Inputs are driven on the falling
// edge, so each request is accepted on the following rising edge and outputs
// are sampled on falling edges, away from the active edge.
// -----------------------------------------------------------------------------
module tb_mdu_hilo;

`ifdef MDU_FAST_MUL_EN
  localparam int MulCycles = 1;
`else
  localparam int MulCycles = 33;
`endif
  localparam int DivCycles = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  opIn = 3'b000;
  logic [31:0] aIn = '0;
  logic [31:0] bIn = '0;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checkCount = 0;
  int passCount  = 0;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (opIn),
    .A     (aIn),
    .B     (bIn),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // Drive a request at the current falling edge; it is accepted on the next
  // rising edge and start drops at the falling edge after that
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    opIn  = o;
    aIn   = a;
    bIn   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges with busy high (bounded), then check the result and
  // the done pulse; optionally check that done lasts exactly one cycle
  task automatic waitDone(input string tag, input int already, input int expCycles,
                          input logic [31:0] expHi, input logic [31:0] expLo,
                          input bit checkDrop);
    int cnt;
    cnt = already;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput({tag, "_busyCycles"}, 64'(cnt), 64'(expCycles));
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_HI"}, 64'(HI), 64'(expHi));
    checkOutput({tag, "_LO"}, 64'(LO), 64'(expLo));
    if (checkDrop) begin
      @(negedge clk);
      checkOutput({tag, "_doneDrop"}, 64'(done), 64'd0);
      checkOutput({tag, "_busyIdle"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #2;
    checkOutput("reset_HI", 64'(HI), 64'd0);
    checkOutput("reset_LO", 64'(LO), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // MULT -3 * 7
    applyStimulus(3'b000, 32'hFFFF_FFFD, 32'd7);
    checkOutput("mult_busyAfterAccept", 64'(busy), 64'd1);
    aIn = 32'hDEAD_BEEF;
    bIn = 32'h1234_5678;
    waitDone("mult", 0, MulCycles, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);

    // MULTU 0xFFFFFFFF squared; HI must hold its old value during the run
    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu_hiHeld", 64'(HI), 64'hFFFF_FFFF);
    checkOutput("multu_loHeld", 64'(LO), 64'hFFFF_FFEB);
    waitDone("multu", 0, MulCycles, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);

    // MTLO writes LO next edge without busy or done
    applyStimulus(3'b101, 32'h1234_5678, 32'd0);
    checkOutput("mtlo_LO", 64'(LO), 64'h1234_5678);
    checkOutput("mtlo_HI", 64'(HI), 64'hFFFF_FFFE);
    checkOutput("mtlo_busy", 64'(busy), 64'd0);
    checkOutput("mtlo_done", 64'(done), 64'd0);

    // Reserved op is ignored
    applyStimulus(3'b110, 32'hAAAA_AAAA, 32'h5555_5555);
    checkOutput("rsvd_busy", 64'(busy), 64'd0);
    checkOutput("rsvd_HI", 64'(HI), 64'hFFFF_FFFE);
    checkOutput("rsvd_LO", 64'(LO), 64'h1234_5678);

    // DIV -7 / 2: quotient -3, remainder -1
    applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2);
    waitDone("div", 0, DivCycles, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);

    // DIV signed overflow
    applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("divOvf", 0, DivCycles, 32'h0000_0000, 32'h8000_0000, 1'b1);

    // DIVU by zero
    applyStimulus(3'b011, 32'd100, 32'd0);
    waitDone("divuZero", 0, DivCycles, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);

    // DIV (signed) by zero with a negative dividend
    applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd0);
    waitDone("divZero", 0, DivCycles, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

    // DIVU 100/7 with a MULT 2*3 request while busy, which must be dropped
    applyStimulus(3'b011, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    applyStimulus(3'b000, 32'd2, 32'd3);
    waitDone("divuIgnore", 5, DivCycles, 32'd2, 32'd14, 1'b1);

    // DIVU interrupted by reset: everything clears at once
    applyStimulus(3'b011, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midReset_HI", 64'(HI), 64'd0);
    checkOutput("midReset_LO", 64'(LO), 64'd0);
    checkOutput("midReset_busy", 64'(busy), 64'd0);
    checkOutput("midReset_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("postReset_busy", 64'(busy), 64'd0);

    // MTHI after reset
    applyStimulus(3'b100, 32'd5, 32'd0);
    checkOutput("mthi_HI", 64'(HI), 64'd5);
    checkOutput("mthi_LO", 64'(LO), 64'd0);
    checkOutput("mthi_busy", 64'(busy), 64'd0);

    // Back-to-back: MULT 6*7 accepted in the cycle done pulses for DIVU 50/5
    applyStimulus(3'b011, 32'd50, 32'd5);
    waitDone("divuB2b", 0, DivCycles, 32'd0, 32'd10, 1'b0);
    applyStimulus(3'b000, 32'd6, 32'd7);
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    checkOutput("b2b_doneCleared", 64'(done), 64'd0);
    waitDone("mult6x7", 0, MulCycles, 32'd0, 32'd42, 1'b1);

    // MULT with negative times negative
    applyStimulus(3'b000, 32'hFFFF_FFFA, 32'hFFFF_FFF9);
    waitDone("multNegNeg", 0, MulCycles, 32'd0, 32'd42, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
